// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller.
// Contents: FSM state encoding, error codes and the default sync marker.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame controller.
// It is a MAX_LEN x 8 register array with one synchronous write port and one combinational read port.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          i_Clock,
  input  logic          i_We,
  input  logic [AW-1:0] i_Wr_Addr,
  input  logic [7:0]    i_Wr_Data,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [7:0]    o_Rd_Data
);

  logic [7:0] mem_q [MAX_LEN];

  // Contents are meaningful only while a frame is held, so no reset is needed.
  always_ff @(posedge i_Clock) begin
    if (i_We) begin
      mem_q[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller behind the UART receiver. Frame format: sync, cmd, len, payload, XOR checksum.
// Optional per-event statistics counters are enabled by defining UART_FRAME_STATS_EN.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 17400,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Frame_Valid,
  input  logic        i_Frame_Ack,
  output logic [7:0]  o_Cmd,
  output logic [7:0]  o_Len,
  input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] i_Rd_Addr,
  output logic [7:0]  o_Rd_Data,
  output logic        o_Err_Valid,
  output logic [1:0]  o_Err_Code,
  output logic        o_Overrun
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0] o_Good_Cnt,
  output logic [15:0] o_Err_Cnt,
  output logic [15:0] o_Ovr_Cnt
`endif
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q, overrun_d;
  logic          buf_we;
  logic          active;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;
    active      = (state_q == S_CMD) || (state_q == S_LEN) ||
                  (state_q == S_PAYLOAD) || (state_q == S_CSUM);

    if (active) begin
      tmo_d = i_Rx_DV ? '0 : tmo_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = S_CMD;
      end
      S_CMD: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          csum_d  = i_Rx_Byte;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte > MAX_LEN_B) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d  = i_Rx_Byte;
            csum_d = csum_q ^ i_Rx_Byte;
            if (i_Rx_Byte == 8'd0) begin
              state_d = S_CSUM;
            end else begin
              idx_d   = '0;
              state_d = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ i_Rx_Byte;
          idx_d  = idx_q + AW'(1);
          if (8'(idx_q) == (len_q - 8'd1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == csum_q) begin
            state_d = S_HOLD;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // The buffer stays frozen until the consumer acks, so any arriving byte is lost.
        if (i_Rx_DV) overrun_d = 1'b1;
        if (i_Frame_Ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe in the expiry cycle wins over the timeout.
    if (active && !i_Rx_DV && (tmo_q == TMO_MAX)) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = S_IDLE;
      tmo_d       = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .i_Clock   (i_Clock),
    .i_We      (buf_we),
    .i_Wr_Addr (idx_q),
    .i_Wr_Data (i_Rx_Byte),
    .i_Rd_Addr (i_Rd_Addr),
    .o_Rd_Data (o_Rd_Data)
  );

  assign o_Frame_Valid = (state_q == S_HOLD);
  assign o_Cmd         = cmd_q;
  assign o_Len         = len_q;
  assign o_Err_Valid   = err_valid_q;
  assign o_Err_Code    = err_code_q;
  assign o_Overrun     = overrun_q;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Counters advance alongside the event they count and stick at all-ones.
  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    if ((state_d == S_HOLD) && (state_q != S_HOLD) && (good_cnt_q != 16'hFFFF))
      good_cnt_d = good_cnt_q + 16'd1;
    if (err_valid_d && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
    if (overrun_d && (ovr_cnt_q != 16'hFFFF))
      ovr_cnt_d = ovr_cnt_q + 16'd1;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign o_Good_Cnt = good_cnt_q;
  assign o_Err_Cnt  = err_cnt_q;
  assign o_Ovr_Cnt  = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed and randomized checks of uart_frame_ctrl against a frame-level reference model.
// Statistics outputs are checked when UART_FRAME_STATS_EN is defined.
module tb_uart_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          frame_valid;
  logic          ack;
  logic [7:0]    cmd;
  logic [7:0]    len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          overrun;
`ifdef UART_FRAME_STATS_EN
  logic [15:0]   good_cnt, err_cnt, ovr_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TMO),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Frame_Valid (frame_valid),
    .i_Frame_Ack   (ack),
    .o_Cmd         (cmd),
    .o_Len         (len),
    .i_Rd_Addr     (rd_addr),
    .o_Rd_Data     (rd_data),
    .o_Err_Valid   (err_valid),
    .o_Err_Code    (err_code),
    .o_Overrun     (overrun)
`ifdef UART_FRAME_STATS_EN
    ,
    .o_Good_Cnt    (good_cnt),
    .o_Err_Cnt     (err_cnt),
    .o_Ovr_Cnt     (ovr_cnt)
`endif
  );

  always @(negedge clk) if (err_valid === 1'b1) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] f[$], input int max_gap);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i]);
      if (i != f.size() - 1) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("valid_after_ack", {31'd0, frame_valid}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = AW'(addr);
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  // Outcome of a frame: 0 = good, 1 = error with the given code.
  function automatic void predict(input logic [7:0] f[$], output int kind, output logic [1:0] code);
    logic [7:0] x;
    if (int'(f[2]) > MAX_LEN) begin
      kind = 1; code = 2'b10;
      return;
    end
    x = 8'h00;
    for (int i = 1; i < f.size() - 1; i++) x ^= f[i];
    if (x == f[f.size() - 1]) begin
      kind = 0; code = 2'b00;
    end else begin
      kind = 1; code = 2'b01;
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int kind, n, snap;
    logic [1:0] code;
    logic [7:0] b, cs;
    int ln;

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; ack = 1'b0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_cmd", {24'd0, cmd}, 32'd0);
    chk("rst_len", {24'd0, len}, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef UART_FRAME_STATS_EN
    chk("rst_good_cnt", {16'd0, good_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Good frame
    q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(q, 0);
    chk("good_valid", {31'd0, frame_valid}, 32'd1);
    chk("good_cmd", {24'd0, cmd}, 32'h01);
    chk("good_len", {24'd0, len}, 32'h02);
    rd_chk("good_rd0", 0, 8'h10);
    rd_chk("good_rd1", 1, 8'h20);
    do_ack();
    $display("good frame done");

    // Zero-length frame
    q = '{8'hA5, 8'h7E, 8'h00, 8'h7E};
    send_q(q, 2);
    chk("zero_valid", {31'd0, frame_valid}, 32'd1);
    chk("zero_len", {24'd0, len}, 32'd0);
    do_ack();
    $display("zero-length frame done");

    // Bad checksum
    q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    snap = err_pulses;
    send_q(q, 1);
    chk("csum_err_valid", {31'd0, err_valid}, 32'd1);
    chk("csum_err_code", {30'd0, err_code}, 32'd1);
    chk("csum_no_frame", {31'd0, frame_valid}, 32'd0);
    tick();
    chk("csum_pulse_width", {31'd0, err_valid}, 32'd0);
    chk("csum_code_hold", {30'd0, err_code}, 32'd1);
    chk("csum_pulse_count", 32'(err_pulses - snap), 32'd1);
    $display("bad checksum done");

    // Length error then a good frame
    q = '{8'hA5, 8'h01, 8'h11};
    send_q(q, 1);
    chk("len_err_valid", {31'd0, err_valid}, 32'd1);
    chk("len_err_code", {30'd0, err_code}, 32'd2);
    q = '{8'hA5, 8'h01, 8'h00, 8'h01};
    send_q(q, 1);
    chk("len_follow_valid", {31'd0, frame_valid}, 32'd1);
    chk("len_follow_cmd", {24'd0, cmd}, 32'h01);
    do_ack();
    $display("length error done");

    // Timeout: error becomes visible TMO cycles after the last strobe
    send_byte(8'hA5);
    send_byte(8'h01);
    n = 0;
    while ((err_valid !== 1'b1) && (n < 2 * TMO)) begin
      tick();
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TMO));
    chk("tmo_code", {30'd0, err_code}, 32'd3);
    q = '{8'hA5, 8'h03, 8'h00, 8'h03};
    send_q(q, 0);
    chk("tmo_recover_valid", {31'd0, frame_valid}, 32'd1);
    chk("tmo_recover_cmd", {24'd0, cmd}, 32'h03);
    do_ack();
    $display("timeout done");

    // Strobe in the expiry cycle wins
    snap = err_pulses;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO - 1) tick();
    send_byte(8'h00);
    send_byte(8'h01);
    chk("expiry_valid", {31'd0, frame_valid}, 32'd1);
    tick();
    chk("expiry_no_err", 32'(err_pulses - snap), 32'd0);
    do_ack();
    $display("expiry race done");

    // Overrun while holding, then ack and byte in the same cycle
    q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(q, 1);
    send_byte(8'h55);
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ovr_valid_kept", {31'd0, frame_valid}, 32'd1);
    chk("ovr_cmd_kept", {24'd0, cmd}, 32'h01);
    chk("ovr_len_kept", {24'd0, len}, 32'h02);
    rd_chk("ovr_rd0_kept", 0, 8'h10);
    rd_chk("ovr_rd1_kept", 1, 8'h20);
    tick();
    chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    rx_byte = 8'hA5; rx_dv = 1'b1; ack = 1'b1;
    tick();
    rx_dv = 1'b0; ack = 1'b0;
    chk("ack_ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ack_ovr_valid", {31'd0, frame_valid}, 32'd0);
    q = '{8'hA5, 8'h02, 8'h00, 8'h02};
    send_q(q, 0);
    chk("ack_ovr_next_valid", {31'd0, frame_valid}, 32'd1);
    chk("ack_ovr_next_cmd", {24'd0, cmd}, 32'h02);
    do_ack();
    $display("overrun done");

    // Reset mid-payload
    snap = err_pulses;
    q = '{8'hA5, 8'h01, 8'h03, 8'hAA};
    send_q(q, 0);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("mid_rst_cmd", {24'd0, cmd}, 32'd0);
    chk("mid_rst_len", {24'd0, len}, 32'd0);
    chk("mid_rst_err_code", {30'd0, err_code}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_err", 32'(err_pulses - snap), 32'd0);
    q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(q, 1);
    chk("post_rst_valid", {31'd0, frame_valid}, 32'd1);
    rd_chk("post_rst_rd1", 1, 8'h20);
`ifdef UART_FRAME_STATS_EN
    chk("post_rst_good_cnt", {16'd0, good_cnt}, 32'd1);
    chk("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("post_rst_ovr_cnt", {16'd0, ovr_cnt}, 32'd0);
`endif
    do_ack();
    $display("reset mid-frame done");

    // Randomized frames against the reference model
    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
      end
      q = {};
      q.push_back(8'hA5);
      q.push_back(8'($urandom));
      ln = $urandom_range(0, MAX_LEN + 3);
      q.push_back(8'(ln));
      if (ln <= MAX_LEN) begin
        for (int j = 0; j < ln; j++) q.push_back(8'($urandom));
        cs = 8'h00;
        for (int j = 1; j < q.size(); j++) cs ^= q[j];
        if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(cs);
      end
      predict(q, kind, code);
      snap = err_pulses;
      send_q(q, 3);
      if (kind == 0) begin
        chk("rnd_valid", {31'd0, frame_valid}, 32'd1);
        chk("rnd_cmd", {24'd0, cmd}, {24'd0, q[1]});
        chk("rnd_len", {24'd0, len}, {24'd0, q[2]});
        for (int j = 0; j < ln; j++) rd_chk("rnd_payload", j, q[3 + j]);
        tick();
        chk("rnd_no_err", 32'(err_pulses - snap), 32'd0);
        do_ack();
      end else begin
        chk("rnd_err_valid", {31'd0, err_valid}, 32'd1);
        chk("rnd_err_code", {30'd0, err_code}, {30'd0, code});
        chk("rnd_err_no_frame", {31'd0, frame_valid}, 32'd0);
        tick();
      end
      $display("random frame %0d len=%0d kind=%0d", f, ln, kind);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Frame-level controller sitting directly behind the UART receiver. It consumes the receiver's byte strobe and byte, then runs a framing state machine over the stream. Frame format: sync 0xA5, command, length, payload, checksum. Validated frames are buffered and handed to the register/command layer with a valid/ack handshake; malformed or stalled frames are discarded and reported.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; also the depth of the payload buffer (1..255).
TIMEOUT_CLKS, 17400, inter-byte timeout in clocks (about 4 character times at 435 clocks/bit).
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
i_Clock  in  1  system clock.
i_Rst_n  in  1  reset: synchronous, active-low.
i_Rx_DV  in  1  one-cycle byte strobe from the UART receiver.
i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1.
o_Frame_Valid  out  1  complete good frame held; stays high until acknowledged.
i_Frame_Ack  in  1  consumer acknowledge; only meaningful while o_Frame_Valid=1.
o_Cmd  out  8  command byte of the held frame.
o_Len  out  8  payload length of the held frame.
i_Rd_Addr  in  $clog2(MAX_LEN)  payload buffer read index.
o_Rd_Data  out  8  payload byte at i_Rd_Addr; combinational read.
o_Err_Valid  out  1  one-cycle error pulse.
o_Err_Code  out  2  error type: 01 checksum, 10 length, 11 timeout; qualified by o_Err_Valid.
o_Overrun  out  1  one-cycle pulse when a byte is dropped because a frame is held.

Behaviour:
- Reset (i_Rst_n=0 at a clock edge), applied at every output:
  - o_Frame_Valid=0, o_Cmd=0, o_Len=0, o_Err_Valid=0, o_Err_Code=0, o_Overrun=0.
  - State returns to S_IDLE; timeout counter and running checksum are cleared.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial frame and reports no error.
- States and transitions (each transition happens on the clock edge where i_Rx_DV=1, unless noted):
  - S_IDLE: a byte equal to SYNC_BYTE -> S_CMD; any other byte is ignored.
  - S_CMD: capture cmd; checksum := byte; -> S_LEN.
  - S_LEN:
    - Length greater than MAX_LEN -> error 10, back to S_IDLE.
    - Otherwise capture len and XOR it into the checksum.
    - len=0 -> S_CSUM; otherwise clear the write index -> S_PAYLOAD.
  - S_PAYLOAD: write the byte at the write index, XOR it into the checksum, increment the index. When index reaches len-1 -> S_CSUM.
  - S_CSUM:
    - Byte == checksum -> S_HOLD, o_Frame_Valid=1 the following cycle (1-cycle latency from the last strobe).
    - Mismatch -> error 01, back to S_IDLE.
  - S_HOLD: i_Frame_Ack=1 -> o_Frame_Valid=0 next cycle, back to S_IDLE. Any byte arriving while in S_HOLD is dropped and pulses o_Overrun, including a byte in the ack cycle.
- Checksum: 8-bit XOR of cmd, len and every payload byte. The sync byte is excluded.
- Timeout:
  - The counter runs only in S_CMD, S_LEN, S_PAYLOAD and S_CSUM, and clears to 0 on every i_Rx_DV.
  - When the counter reaches TIMEOUT_CLKS-1 without a strobe -> error 11, back to S_IDLE.
  - A strobe arriving in the same cycle the counter expires wins: the byte is processed and no timeout is raised.
- Error reporting: o_Err_Valid pulses exactly one cycle, in the cycle after the detecting edge. o_Err_Code holds its last value until the next error.
- A sync byte seen mid-frame is treated as ordinary data; there is no resync.
- o_Cmd, o_Len and the buffer are only guaranteed while o_Frame_Valid=1.
- i_Rd_Addr >= o_Len returns stale data; this is not an error.
- The timeout counter is $clog2(TIMEOUT_CLKS) bits wide; the write index is $clog2(MAX_LEN) bits wide.

Optional Feature:
UART_FRAME_STATS_EN.
- Defined: adds three 16-bit saturating outputs, o_Good_Cnt, o_Err_Cnt and o_Ovr_Cnt.
  - o_Good_Cnt increments on entry to S_HOLD.
  - o_Err_Cnt increments on each o_Err_Valid pulse.
  - o_Ovr_Cnt increments on each o_Overrun pulse.
  - All three hold at 16'hFFFF once saturated and clear to 0 on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding S_IDLE..S_HOLD (3 bits);
  - the error codes ERR_CSUM, ERR_LEN, ERR_TIMEOUT;
  - the default SYNC_BYTE.
- One sub-module: uart_frame_buf, a MAX_LEN x 8 register array with a synchronous write port and an asynchronous read port. The controller FSM, checksum and timeout logic stay in uart_frame_ctrl.

Test Plan:
- Good frame: bytes A5,01,02,10,20,33 -> o_Frame_Valid=1 one cycle after the last strobe; o_Cmd=01, o_Len=02, Rd[0]=10, Rd[1]=20. Ack -> o_Frame_Valid=0 next cycle.
- Zero-length frame: A5,7E,00,7E -> o_Frame_Valid=1, o_Len=0. Bad checksum A5,01,02,10,20,34 -> one o_Err_Valid pulse with code 01, no frame.
- Length error: A5,01,11 with MAX_LEN=16 -> error 10. A following A5,01,00,01 is then accepted.
- Timeout: A5,01, then silence for TIMEOUT_CLKS cycles -> error 11, back to idle. A strobe arriving exactly at expiry -> no error.
- Overrun: hold a frame without ack, send 55 -> o_Overrun pulses and the held frame is unchanged. Ack and a new byte in the same cycle -> byte dropped, o_Overrun=1.
- Reset mid-payload (after A5,01,03,AA) -> all outputs 0, no error pulse. A following good frame is received correctly; with UART_FRAME_STATS_EN, o_Good_Cnt=1.
